// File: rtl/root_window_accum_if.sv
// Sample-in / window-out handshake bundle for root_window_accum.
// The slave modport is the accumulator; the master modport is the producer/consumer side.
interface root_window_accum_if #(
    parameter int NBITS = 8,
    parameter int SUMW  = NBITS + 8
);
    logic [NBITS-1:0] IN_DATA;
    logic             IN_VALID;
    logic             IN_READY;
    logic             FLUSH;
    logic [SUMW-1:0]  OUT_SUM;
    logic [NBITS-1:0] OUT_MIN;
    logic [NBITS-1:0] OUT_MAX;
    logic [7:0]       OUT_COUNT;
    logic             OUT_VALID;
    logic             OUT_READY;

    modport slave (
        input  IN_DATA, IN_VALID, FLUSH, OUT_READY,
        output IN_READY, OUT_SUM, OUT_MIN, OUT_MAX, OUT_COUNT, OUT_VALID
    );

    modport master (
        output IN_DATA, IN_VALID, FLUSH, OUT_READY,
        input  IN_READY, OUT_SUM, OUT_MIN, OUT_MAX, OUT_COUNT, OUT_VALID
    );
endinterface

// File: rtl/root_window_accum.sv
// Windowed sum/min/max/count over the XOUT stream, with a one-deep output slot
// so the next window keeps accumulating while the finished one waits.
module root_window_accum #(
    parameter int NBITS = 8,
    parameter int WIN   = 4,
    parameter int SUMW  = NBITS + 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    root_window_accum_if.slave   bus
);
    localparam logic [7:0] WIN_CNT  = 8'(WIN);
    localparam logic [7:0] WIN_LAST = 8'(WIN - 1);

    logic [SUMW-1:0]  r_acc_sum;
    logic [NBITS-1:0] r_acc_min;
    logic [NBITS-1:0] r_acc_max;
    logic [7:0]       r_acc_cnt;
    logic             r_flush_pend;
    logic [SUMW-1:0]  r_out_sum;
    logic [NBITS-1:0] r_out_min;
    logic [NBITS-1:0] r_out_max;
    logic [7:0]       r_out_count;
    logic             r_out_valid;

    logic             w_slot_free;
    logic             w_in_ready;
    logic             w_accept;
    logic [SUMW-1:0]  w_new_sum;
    logic [NBITS-1:0] w_new_min;
    logic [NBITS-1:0] w_new_max;
    logic [7:0]       w_new_cnt;
    logic             w_close;
    logic             w_flush_req;
    logic             w_flush_emit;
    logic             w_load;
    logic             w_flush_pend_next;

    assign w_slot_free = !r_out_valid || bus.OUT_READY;
    // Stall only when this edge would need to load a slot that is still occupied.
    assign w_in_ready  = RST_N
                       && !(r_acc_cnt == WIN_LAST && !w_slot_free)
                       && !(r_flush_pend && r_acc_cnt != 8'd0 && !w_slot_free);
    assign w_accept    = bus.IN_VALID && w_in_ready;

    always_comb begin
        w_new_sum = r_acc_sum;
        w_new_min = r_acc_min;
        w_new_max = r_acc_max;
        w_new_cnt = r_acc_cnt;
        if (w_accept) begin
            w_new_sum = r_acc_sum + {{(SUMW - NBITS){1'b0}}, bus.IN_DATA};
            if (r_acc_cnt == 8'd0 || bus.IN_DATA < r_acc_min) begin
                w_new_min = bus.IN_DATA;
            end
            if (r_acc_cnt == 8'd0 || bus.IN_DATA > r_acc_max) begin
                w_new_max = bus.IN_DATA;
            end
            w_new_cnt = r_acc_cnt + 8'd1;
        end
    end

    assign w_close      = w_accept && (w_new_cnt == WIN_CNT);
    assign w_flush_req  = r_flush_pend || bus.FLUSH;
    assign w_flush_emit = !w_close && w_flush_req && (w_new_cnt != 8'd0) && w_slot_free;
    assign w_load       = w_close || w_flush_emit;

    // A close or flush-emit empties the accumulator, which also satisfies any flush.
    always_comb begin
        w_flush_pend_next = w_flush_req;
        if (w_load || w_new_cnt == 8'd0) begin
            w_flush_pend_next = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_acc_sum    <= '0;
            r_acc_min    <= '0;
            r_acc_max    <= '0;
            r_acc_cnt    <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_flush_pend <= w_flush_pend_next;
            if (w_load) begin
                r_acc_sum <= '0;
                r_acc_min <= '0;
                r_acc_max <= '0;
                r_acc_cnt <= '0;
            end else begin
                r_acc_sum <= w_new_sum;
                r_acc_min <= w_new_min;
                r_acc_max <= w_new_max;
                r_acc_cnt <= w_new_cnt;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_out_sum   <= '0;
            r_out_min   <= '0;
            r_out_max   <= '0;
            r_out_count <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_sum   <= w_new_sum;
            r_out_min   <= w_new_min;
            r_out_max   <= w_new_max;
            r_out_count <= w_new_cnt;
            r_out_valid <= 1'b1;
        end else if (bus.OUT_READY) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.IN_READY  = w_in_ready;
    assign bus.OUT_SUM   = r_out_sum;
    assign bus.OUT_MIN   = r_out_min;
    assign bus.OUT_MAX   = r_out_max;
    assign bus.OUT_COUNT = r_out_count;
    assign bus.OUT_VALID = r_out_valid;
endmodule

// File: tb/tb_root_window_accum.sv
// Bench for root_window_accum: WIN=4 instance checked every cycle against a
// queue-based window model; WIN=255 and WIN=1 instances checked directly.
module tb_root_window_accum;
    localparam int W = 4;

    logic CLK;
    logic RST_N;
    int   checks   = 0;
    int   failures = 0;

    root_window_accum_if #(.NBITS(8), .SUMW(16)) a_if ();
    root_window_accum_if #(.NBITS(8), .SUMW(16)) b_if ();
    root_window_accum_if #(.NBITS(8), .SUMW(16)) c_if ();

    root_window_accum #(.NBITS(8), .WIN(W),   .SUMW(16)) u_w4   (.CLK(CLK), .RST_N(RST_N), .bus(a_if));
    root_window_accum #(.NBITS(8), .WIN(255), .SUMW(16)) u_w255 (.CLK(CLK), .RST_N(RST_N), .bus(b_if));
    root_window_accum #(.NBITS(8), .WIN(1),   .SUMW(16)) u_w1   (.CLK(CLK), .RST_N(RST_N), .bus(c_if));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Window model: samples of the open window, flush request, and the output slot.
    int cur[$];
    bit m_fp;
    bit m_slot;
    int m_sum, m_min, m_max, m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_load();
        m_sum = 0;
        m_min = 255;
        m_max = 0;
        foreach (cur[i]) begin
            m_sum += cur[i];
            if (cur[i] < m_min) m_min = cur[i];
            if (cur[i] > m_max) m_max = cur[i];
        end
        m_cnt  = cur.size();
        m_slot = 1'b1;
        cur.delete();
    endtask

    task automatic model_reset();
        cur.delete();
        m_fp   = 1'b0;
        m_slot = 1'b0;
    endtask

    // One cycle on the WIN=4 instance: drive, compare against model, advance model.
    task automatic step4(input bit v, input int d, input bit f, input bit ordy);
        bit slot_free;
        bit exp_rdy;
        bit fp;
        @(negedge CLK);
        a_if.IN_VALID  = v;
        a_if.IN_DATA   = 8'(d);
        a_if.FLUSH     = f;
        a_if.OUT_READY = ordy;
        #1;
        slot_free = !m_slot || ordy;
        exp_rdy   = !(cur.size() == W - 1 && !slot_free) && !(m_fp && cur.size() != 0 && !slot_free);
        chk("in_ready", a_if.IN_READY, exp_rdy);
        chk("out_valid", a_if.OUT_VALID, m_slot);
        if (m_slot) begin
            chk("out_sum", a_if.OUT_SUM, m_sum);
            chk("out_min", a_if.OUT_MIN, m_min);
            chk("out_max", a_if.OUT_MAX, m_max);
            chk("out_count", a_if.OUT_COUNT, m_cnt);
        end
        $display("step v=%0d d=%0d f=%0d ordy=%0d rdy=%0d ov=%0d sum=%0d cnt=%0d",
                 v, d, f, ordy, a_if.IN_READY, a_if.OUT_VALID, a_if.OUT_SUM, a_if.OUT_COUNT);
        if (m_slot && ordy) m_slot = 1'b0;
        if (v && exp_rdy) cur.push_back(d);
        fp = m_fp || f;
        if (cur.size() == W) begin
            model_load();
            m_fp = 1'b0;
        end else if (fp && cur.size() == 0) begin
            m_fp = 1'b0;
        end else if (fp && slot_free) begin
            model_load();
            m_fp = 1'b0;
        end else begin
            m_fp = fp;
        end
    endtask

    initial begin
        {a_if.IN_VALID, a_if.IN_DATA, a_if.FLUSH, a_if.OUT_READY} = '0;
        {b_if.IN_VALID, b_if.IN_DATA, b_if.FLUSH, b_if.OUT_READY} = '0;
        {c_if.IN_VALID, c_if.IN_DATA, c_if.FLUSH, c_if.OUT_READY} = '0;
        model_reset();
        RST_N = 1'b0;
        #2;
        a_if.IN_VALID = 1'b1;
        #1;
        chk("rst_in_ready", a_if.IN_READY, 0);
        chk("rst_out_valid", a_if.OUT_VALID, 0);
        chk("rst_out_sum", a_if.OUT_SUM, 0);
        chk("rst_out_count", a_if.OUT_COUNT, 0);
        a_if.IN_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        // Back-to-back window, consumer always ready.
        step4(1, 10, 0, 1); step4(1, 20, 0, 1); step4(1, 30, 0, 1); step4(1, 40, 0, 1);
        step4(0, 0, 0, 1);
        chk("t1_sum", a_if.OUT_SUM, 100);
        chk("t1_min", a_if.OUT_MIN, 10);
        chk("t1_max", a_if.OUT_MAX, 40);
        chk("t1_count", a_if.OUT_COUNT, 4);
        step4(0, 0, 0, 1);
        chk("t1_one_cycle", a_if.OUT_VALID, 0);

        // Stall with slot held.
        for (int i = 1; i <= 7; i++) step4(1, i, 0, 0);
        step4(1, 8, 0, 0);
        chk("t2_stall_ready", a_if.IN_READY, 0);
        chk("t2_held_sum", a_if.OUT_SUM, 10);
        step4(1, 8, 0, 1);
        step4(0, 0, 0, 0);
        chk("t2_sum", a_if.OUT_SUM, 26);
        chk("t2_min", a_if.OUT_MIN, 5);
        chk("t2_max", a_if.OUT_MAX, 8);
        step4(0, 0, 0, 1);

        // Partial window flush, then flush of an empty accumulator.
        step4(1, 235, 0, 1); step4(1, 0, 0, 1); step4(0, 0, 1, 1);
        step4(0, 0, 0, 1);
        chk("t3_sum", a_if.OUT_SUM, 235);
        chk("t3_min", a_if.OUT_MIN, 0);
        chk("t3_max", a_if.OUT_MAX, 235);
        chk("t3_count", a_if.OUT_COUNT, 2);
        step4(0, 0, 1, 1); step4(0, 0, 0, 1); step4(0, 0, 0, 1);
        chk("t3_empty_flush", a_if.OUT_VALID, 0);

        // Flush coincident with 3rd accept, then with the closing accept.
        step4(1, 7, 0, 1); step4(1, 7, 0, 1); step4(1, 9, 1, 1);
        step4(0, 0, 0, 1);
        chk("t4_sum", a_if.OUT_SUM, 23);
        chk("t4_count", a_if.OUT_COUNT, 3);
        step4(1, 1, 0, 1); step4(1, 2, 0, 1); step4(1, 3, 0, 1); step4(1, 4, 1, 1);
        step4(0, 0, 0, 1);
        chk("t4_close_count", a_if.OUT_COUNT, 4);
        step4(0, 0, 0, 1);
        chk("t4_single_emit", a_if.OUT_VALID, 0);

        // Flush while the slot is held.
        for (int i = 1; i <= 6; i++) step4(1, i, 0, 0);
        step4(0, 0, 1, 0);
        step4(1, 7, 0, 0);
        chk("t5_flush_stall", a_if.IN_READY, 0);
        step4(0, 0, 0, 1);
        step4(0, 0, 0, 0);
        chk("t5_count", a_if.OUT_COUNT, 2);
        chk("t5_sum", a_if.OUT_SUM, 11);
        step4(0, 0, 0, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step4($urandom_range(0, 9) < 7, $urandom_range(0, 255),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < 8; i++) step4(0, 0, i == 0, 1);

        // WIN=255 with all-max samples.
        for (int i = 0; i < 255; i++) begin
            @(negedge CLK);
            b_if.IN_VALID = 1'b1; b_if.IN_DATA = 8'd255; b_if.OUT_READY = 1'b1;
            #1;
            if (i == 254) chk("w255_ready_last", b_if.IN_READY, 1);
        end
        @(negedge CLK);
        b_if.IN_VALID = 1'b0;
        #1;
        chk("w255_valid", b_if.OUT_VALID, 1);
        chk("w255_sum", b_if.OUT_SUM, 65025);
        chk("w255_min", b_if.OUT_MIN, 255);
        chk("w255_max", b_if.OUT_MAX, 255);
        chk("w255_count", b_if.OUT_COUNT, 255);
        $display("w255 sum=%0d count=%0d", b_if.OUT_SUM, b_if.OUT_COUNT);

        // WIN=1: every sample is its own window.
        for (int i = 0; i < 3; i++) begin
            int s;
            s = $urandom_range(0, 255);
            @(negedge CLK);
            c_if.IN_VALID = 1'b1; c_if.IN_DATA = 8'(s); c_if.OUT_READY = 1'b1;
            @(negedge CLK);
            c_if.IN_VALID = 1'b0;
            #1;
            chk("w1_sum", c_if.OUT_SUM, s);
            chk("w1_min", c_if.OUT_MIN, s);
            chk("w1_max", c_if.OUT_MAX, s);
            chk("w1_count", c_if.OUT_COUNT, 1);
            $display("w1 sample=%0d sum=%0d count=%0d", s, c_if.OUT_SUM, c_if.OUT_COUNT);
        end

        // Reset mid-window with an output held.
        for (int i = 1; i <= 7; i++) step4(1, i * 3, 0, 0);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("mid_rst_valid", a_if.OUT_VALID, 0);
        chk("mid_rst_sum", a_if.OUT_SUM, 0);
        chk("mid_rst_min", a_if.OUT_MIN, 0);
        chk("mid_rst_max", a_if.OUT_MAX, 0);
        chk("mid_rst_ready", a_if.IN_READY, 0);
        chk("mid_rst_w255_valid", b_if.OUT_VALID, 0);
        model_reset();
        a_if.IN_VALID = 1'b0;
        a_if.FLUSH    = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        step4(1, 50, 0, 1); step4(1, 60, 0, 1); step4(1, 70, 0, 1);
        step4(0, 0, 0, 1);
        chk("post_rst_no_early", a_if.OUT_VALID, 0);
        step4(1, 80, 0, 1);
        step4(0, 0, 0, 1);
        chk("post_rst_count", a_if.OUT_COUNT, 4);
        chk("post_rst_sum", a_if.OUT_SUM, 260);
        step4(0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/root_window_accum.md
# root_window_accum

Streaming window accumulator that sits directly downstream of the RootProcess datapath: it accepts the 8-bit XOUT result stream and, for every window of WIN samples, produces the window sum, minimum, maximum and sample count on a registered valid/ready output. Accumulation and output are double-buffered, so a finished window waits in the output slot while the next window keeps accumulating. A FLUSH pulse closes a partial window early.

## Interface
- NBITS, 8, width of input samples (unsigned)
- WIN, 4, samples per window; legal range 1..255
- SUMW, NBITS+8, width of OUT_SUM; no overflow is possible for legal WIN
- CLK  in  1  rising-edge clock
- RST_N  in  1  reset, asynchronous, active-low
- IN_DATA  in  NBITS  sample (XOUT of upstream stage), unsigned
- IN_VALID  in  1  IN_DATA valid
- IN_READY  out  1  block accepts a sample this cycle
- FLUSH  in  1  single-cycle request to close the current partial window
- OUT_SUM  out  SUMW  sum of window samples
- OUT_MIN  out  NBITS  smallest sample in window
- OUT_MAX  out  NBITS  largest sample in window
- OUT_COUNT  out  8  number of samples in window (WIN, or fewer after FLUSH)
- OUT_VALID  out  1  output slot holds a window
- OUT_READY  in  1  consumer takes the output slot

## Operation
- Accept: a sample is accepted on a rising edge where IN_VALID && IN_READY.
- Accumulator registers: acc_sum, acc_min, acc_max, acc_cnt (0..WIN-1). The first accepted sample of a window loads min/max; later samples compare unsigned. acc_sum adds the zero-extended sample.
- Window close: when the accepted sample makes the count equal WIN, the totals including that sample are loaded into the output slot, OUT_VALID is set, and the accumulator clears in the same edge.
- Output slot is free if !OUT_VALID || OUT_READY (it is consumed and reloaded in the same edge).
- IN_READY = RST_N && !(acc_cnt == WIN-1 && !slot_free) && !(flush_pend && acc_cnt != 0 && !slot_free). IN_READY is combinational; it stalls only when a window close or pending flush needs a busy slot.
- FLUSH: sets flush_pend. While flush_pend is set:
  - if acc_cnt == 0 with no sample accepted this edge, flush_pend clears and nothing is emitted;
  - otherwise, on the first edge with the slot free, the partial totals (including any sample accepted that edge) load the slot with OUT_COUNT = count, the accumulator clears, and flush_pend clears.
- A FLUSH in the same cycle as a window-closing accept: the window emits normally, leaving the accumulator empty, so the flush is satisfied without a second emit.
- WIN = 1: every accepted sample emits a window with SUM = MIN = MAX = sample and COUNT = 1.
- Output registers change only when the slot loads; they hold stable while OUT_VALID && !OUT_READY.

## Timing
- Reset (RST_N low, asynchronous): OUT_VALID=0, OUT_SUM=0, OUT_MIN=0, OUT_MAX=0, OUT_COUNT=0, acc_* = 0, flush_pend=0; IN_READY=0 while RST_N is low. Reset mid-window discards the partial window and any held output.
- Latency: if the window-closing sample is accepted at edge t, OUT_VALID rises after edge t and the data is valid in the cycle following t.
- Throughput: one sample per cycle sustained while the consumer keeps OUT_READY high; no bubbles at window boundaries.
- Stall: with the slot occupied and OUT_READY low, the block accepts up to WIN-1 samples of the next window, then holds IN_READY low until OUT_READY.
- FLUSH is edge-sampled; a FLUSH asserted while flush_pend is already set has no extra effect.

## Test plan
- WIN=4, samples 10,20,30,40 back-to-back, OUT_READY=1 -> one cycle after the 4th accept: SUM=100, MIN=10, MAX=40, COUNT=4, OUT_VALID high for exactly one cycle.
- WIN=4, OUT_READY=0, samples 1..8 offered continuously -> first window held (SUM=10); 5,6,7 accepted; IN_READY low with 8 pending. Raise OUT_READY -> window 1 is consumed and 8 is accepted on the same edge; next output is SUM=26, MIN=5, MAX=8.
- WIN=4, samples 235,0 then FLUSH -> SUM=235, MIN=0, MAX=235, COUNT=2. A second FLUSH with an empty accumulator -> no output.
- FLUSH in the same cycle as accepting the 3rd sample (values 7,7,9) -> emit SUM=23, MIN=7, MAX=9, COUNT=3. FLUSH coincident with the 4th (closing) accept -> exactly one output, COUNT=4.
- FLUSH while the slot is held (OUT_READY=0) after 2 samples -> IN_READY drops, no emit; on OUT_READY the partial window emits COUNT=2.
- WIN=255, all samples 255 -> SUM=65025, MIN=MAX=255, COUNT=255. Reset asserted after 3 samples of any window -> all outputs 0; the next window is counted from zero.
